// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB round-robin master arbiter.
//   state_t     : APB master sequencing states (IDLE -> SETUP -> ACCESS)
//   APB_ADDR_W  : default PADDR width
//   APB_DATA_W  : default PWDATA/PRDATA width
//   idx_width() : bit width needed to index n items (minimum 1)
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_master_arbiter_rr.sv
// Combinational round-robin picker. Searches upward from the requester after
// i_last_grant, wrapping around, and returns the first pending requester.
//   i_req        : pending request per requester
//   i_last_grant : index of the most recently granted requester
//   o_grant      : one-hot grant (all zero when nothing is pending)
//   o_idx        : index of the granted requester
//   o_any_req    : at least one request is pending
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            i_req,
    input  logic [idx_width(N)-1:0] i_last_grant,
    output logic [N-1:0]            o_grant,
    output logic [idx_width(N)-1:0] o_idx,
    output logic                    o_any_req
);

    localparam int IW = idx_width(N);

    always_comb begin
        int  w_j;
        logic w_found;
        o_grant   = '0;
        o_idx     = '0;
        o_any_req = |i_req;
        w_found   = 1'b0;
        w_j       = 0;
        // Offset 1..N covers every requester once, ending on last_grant itself.
        for (int k = 1; k <= N; k++) begin
            w_j = (int'(i_last_grant) + k) % N;
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Shares one APB master port between NUM_REQ local requesters.
// Requester handshake: a transfer is accepted on a clock edge where
// req_valid[i] && req_ready[i]; req_ready is one-hot and only asserted in IDLE.
// The requester keeps req_valid and its payload stable until that edge.
// Completion is a one-cycle rsp_valid[owner] pulse with rsp_rdata/rsp_err.
// Ports:
//   PCLK, PRESETn            : clock, asynchronous active-low reset
//   req_valid/ready/addr/
//   wdata/write              : per-requester request channel (flattened slices)
//   rsp_valid/rdata/err      : completion pulse, read data, timeout flag
//   PSEL..PREADY             : APB master signals
//   dbg_state                : current sequencing state, for observation
module apb_rr_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_write,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      PWRITE,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    output state_t                    dbg_state
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t              r_state, w_state_next;
    logic [IW-1:0]       r_last_grant, r_owner, w_gnt_idx;
    logic [NUM_REQ-1:0]  w_gnt_onehot;
    logic                w_any_req;
    logic [CW-1:0]       r_wait_cnt;
    logic                w_done, w_abort;

    logic                r_psel, r_penable, r_pwrite, r_rsp_err;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata, r_rsp_rdata;
    logic [NUM_REQ-1:0]  r_rsp_valid;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_gnt_onehot),
        .o_idx        (w_gnt_idx),
        .o_any_req    (w_any_req)
    );

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE:   if (w_any_req) w_state_next = SETUP;
            SETUP:  w_state_next = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    w_done = 1'b1;
                end else if ((TIMEOUT != 0) && (r_wait_cnt == TO_LAST)) begin
                    w_abort = 1'b1;
                end
                if (w_done || w_abort) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_owner      <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_paddr      <= req_addr[int'(w_gnt_idx) * ADDR_W +: ADDR_W];
                        r_pwdata     <= req_wdata[int'(w_gnt_idx) * DATA_W +: DATA_W];
                        r_pwrite     <= req_write[w_gnt_idx];
                        r_psel       <= 1'b1;
                        r_last_grant <= w_gnt_idx;
                        r_owner      <= w_gnt_idx;
                    end
                end
                SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                end
                ACCESS: begin
                    if (w_done || w_abort) begin
                        r_psel               <= 1'b0;
                        r_penable            <= 1'b0;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_err            <= w_abort;
                        // Writes and aborts never return slave data.
                        r_rsp_rdata          <= (w_done && !r_pwrite) ? PRDATA : '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE) ? w_gnt_onehot : '0;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PWRITE    = r_pwrite;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
module tb_apb_rr_master_arbiter;
  import apb_arb_pkg::*;

  localparam int RSP_W   = 37;  // {rsp_valid[3:0], rsp_err, rsp_rdata}
  localparam int SETUP_W = 33;  // {PWRITE, PADDR}

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [3:0]   req_write = '0;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0]  PADDR, PWDATA, PRDATA;
  state_t       dbg_state;

  apb_rr_master_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PRDATA(PRDATA), .PREADY(PREADY), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  // simple memory-backed APB slave with programmable wait states
  logic [31:0] mem [16];
  int          wait_n = 0;
  logic        stuck = 1'b0;
  int          acc_cnt = 0;

  assign PREADY = PSEL && PENABLE && !stuck && (acc_cnt >= wait_n);
  assign PRDATA = mem[PADDR[5:2]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] = PWDATA;
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [RSP_W-1:0]   exp_q[$];
  logic [SETUP_W-1:0] setup_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_xfer(input int who, input logic wr, input logic [31:0] addr,
                             input logic err, input logic [31:0] rdata, input logic rsp);
    setup_q.push_back({wr, addr});
    if (rsp) exp_q.push_back({4'(1 << who), err, rdata});
  endtask

  // monitor: SETUP phase order, ACCESS length/stability, response pulses
  int          en_cnt = 0;
  int          unstable = 0;
  logic [31:0] seen_addr = '0;
  logic [RSP_W-1:0]   m_rsp;
  logic [SETUP_W-1:0] m_setup;

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      en_cnt = 0;
    end else begin
      if (PSEL && !PENABLE) begin
        if (setup_q.size() == 0) begin
          check("setup_unexpected", {PWRITE, PADDR}, 64'h1_FFFF_FFFF);
        end else begin
          m_setup = setup_q.pop_front();
          check("setup_addr", {PWRITE, PADDR}, m_setup);
        end
        seen_addr = PADDR;
        en_cnt = 0;
      end
      if (PSEL && PENABLE) begin
        en_cnt++;
        if (PADDR != seen_addr) unstable++;
      end
      if (|rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {rsp_valid, rsp_err, rsp_rdata}, 64'h0);
        end else begin
          m_rsp = exp_q.pop_front();
          check("rsp", {rsp_valid, rsp_err, rsp_rdata}, m_rsp);
        end
      end
    end
  end

  // driver
  logic [31:0] a_addr[4];
  logic [31:0] a_data[4];
  logic [3:0]  a_wr;
  int          rem[4];

  task automatic load_payload();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32]  = a_addr[i];
      req_wdata[i*32 +: 32] = a_data[i];
      req_write[i]          = a_wr[i];
    end
  endtask

  task automatic drive_all();
    int cyc;
    logic [3:0] g;
    cyc = 0;
    @(negedge PCLK);
    load_payload();
    for (int i = 0; i < 4; i++) req_valid[i] = (rem[i] > 0);
    while (req_valid != 0 && cyc < 400) begin
      #1;
      g = req_ready & req_valid;
      @(posedge PCLK);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          rem[i]--;
          if (rem[i] == 0) req_valid[i] = 1'b0;
        end
      end
      @(negedge PCLK);
      cyc++;
    end
    if (cyc >= 400) begin
      check("drive_timeout", 64'(cyc), 64'd0);
      req_valid = '0;
    end
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || setup_q.size() != 0) && cyc < 200) begin
      @(negedge PCLK);
      cyc++;
    end
    if (cyc >= 200) check("done_timeout", 64'(cyc), 64'd0);
    @(negedge PCLK);
  endtask

  task automatic clear_rem();
    for (int i = 0; i < 4; i++) rem[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    for (int i = 0; i < 4; i++) begin a_addr[i] = '0; a_data[i] = '0; end
    a_wr = '0;
    clear_rem();

    repeat (3) @(negedge PCLK);
    // reset state
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_state", dbg_state, IDLE);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("idle_no_ready", req_ready, 0);

    // 1: single write from requester 1, zero wait states, cycle timing
    a_addr[1] = 32'h1000; a_data[1] = 32'hABCD1234; a_wr = 4'b0010;
    expect_xfer(1, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b1);
    load_payload();
    req_valid = 4'b0010;
    #1 check("t1_ready", req_ready, 4'b0010);
    @(posedge PCLK); #1 req_valid = '0;
    @(negedge PCLK);
    check("t1_setup_psel", PSEL, 1);
    check("t1_setup_penable", PENABLE, 0);
    @(negedge PCLK);
    check("t1_access_penable", PENABLE, 1);
    check("t1_access_ready_low", req_ready, 0);
    @(negedge PCLK);
    check("t1_rsp_valid", rsp_valid, 4'b0010);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_psel_drop", PSEL, 0);
    wait_done();
    check("t1_mem", mem[0], 32'hABCD1234);

    // 2: read from requester 0 with two wait states
    wait_n = 2;
    a_addr[0] = 32'h1000; a_wr = 4'b0000;
    clear_rem(); rem[0] = 1;
    expect_xfer(0, 1'b0, 32'h1000, 1'b0, 32'hABCD1234, 1'b1);
    unstable = 0;
    drive_all();
    wait_done();
    check("t2_access_len", 64'(en_cnt), 3);
    check("t2_addr_stable", 64'(unstable), 0);
    wait_n = 0;

    // align pointer: single read from requester 3
    a_addr[3] = 32'h0C;
    clear_rem(); rem[3] = 1;
    expect_xfer(3, 1'b0, 32'h0C, 1'b0, 32'h5A000003, 1'b1);
    drive_all();
    wait_done();

    // 3: all four valid, requester 0 stays valid for a second turn
    a_addr[0] = 32'h00; a_addr[1] = 32'h04; a_addr[2] = 32'h08; a_addr[3] = 32'h0C;
    a_wr = 4'b0000;
    clear_rem(); rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    expect_xfer(0, 1'b0, 32'h00, 1'b0, 32'hABCD1234, 1'b1);
    expect_xfer(1, 1'b0, 32'h04, 1'b0, 32'h5A000001, 1'b1);
    expect_xfer(2, 1'b0, 32'h08, 1'b0, 32'h5A000002, 1'b1);
    expect_xfer(3, 1'b0, 32'h0C, 1'b0, 32'h5A000003, 1'b1);
    expect_xfer(0, 1'b0, 32'h00, 1'b0, 32'hABCD1234, 1'b1);
    drive_all();
    wait_done();

    // 4a: requesters 0 and 2 with last_grant=0 -> 2 first, then 0
    a_addr[0] = 32'h10; a_wr = 4'b0100;
    a_addr[2] = 32'h14; a_data[2] = 32'hCAFEF00D;
    clear_rem(); rem[0] = 1; rem[2] = 1;
    expect_xfer(2, 1'b1, 32'h14, 1'b0, 32'h0, 1'b1);
    expect_xfer(0, 1'b0, 32'h10, 1'b0, 32'h5A000004, 1'b1);
    drive_all();
    wait_done();
    // single read from 2 sets last_grant=2
    a_wr = 4'b0000;
    clear_rem(); rem[2] = 1;
    expect_xfer(2, 1'b0, 32'h14, 1'b0, 32'hCAFEF00D, 1'b1);
    drive_all();
    wait_done();
    // 4b: requesters 0 and 2 with last_grant=2 -> 0 first (wrap), then 2
    a_addr[0] = 32'h14; a_addr[2] = 32'h10;
    clear_rem(); rem[0] = 1; rem[2] = 1;
    expect_xfer(0, 1'b0, 32'h14, 1'b0, 32'hCAFEF00D, 1'b1);
    expect_xfer(2, 1'b0, 32'h10, 1'b0, 32'h5A000004, 1'b1);
    drive_all();
    wait_done();

    // 5: PREADY stuck low -> timeout abort after 16 ACCESS cycles
    stuck = 1'b1;
    a_addr[1] = 32'h04;
    clear_rem(); rem[1] = 1;
    expect_xfer(1, 1'b0, 32'h04, 1'b1, 32'h0, 1'b1);
    drive_all();
    wait_done();
    check("t5_access_len", 64'(en_cnt), 16);
    check("t5_psel_drop", PSEL, 0);
    check("t5_penable_drop", PENABLE, 0);
    stuck = 1'b0;
    a_addr[3] = 32'h08;
    clear_rem(); rem[3] = 1;
    expect_xfer(3, 1'b0, 32'h08, 1'b0, 32'h5A000002, 1'b1);
    drive_all();
    wait_done();
    check("t5_next_len", 64'(en_cnt), 1);

    // 6: reset asserted mid-ACCESS, then arbitration restarts at requester 0
    stuck = 1'b1;
    a_addr[2] = 32'h18;
    clear_rem(); rem[2] = 1;
    expect_xfer(2, 1'b0, 32'h18, 1'b0, 32'h0, 1'b0);
    drive_all();
    for (int k = 0; k < 20 && !PENABLE; k++) @(negedge PCLK);
    repeat (3) @(negedge PCLK);
    check("t6_in_access", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("t6_async_psel", PSEL, 0);
    check("t6_async_penable", PENABLE, 0);
    check("t6_async_rsp_valid", rsp_valid, 0);
    check("t6_setup_consumed", 64'(setup_q.size()), 0);
    @(negedge PCLK);
    stuck = 1'b0;
    PRESETn = 1'b1;
    a_addr[0] = 32'h00; a_addr[1] = 32'h04; a_addr[2] = 32'h08; a_addr[3] = 32'h0C;
    a_wr = 4'b0000;
    clear_rem(); rem[0] = 1; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    expect_xfer(0, 1'b0, 32'h00, 1'b0, 32'hABCD1234, 1'b1);
    expect_xfer(1, 1'b0, 32'h04, 1'b0, 32'h5A000001, 1'b1);
    expect_xfer(2, 1'b0, 32'h08, 1'b0, 32'h5A000002, 1'b1);
    expect_xfer(3, 1'b0, 32'h0C, 1'b0, 32'h5A000003, 1'b1);
    drive_all();
    wait_done();
    check("end_rsp_queue_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // absolute time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

endmodule
